// File: rtl/pattern_seq_detector.sv
// rtl/pattern_seq_detector.sv - serial bit-pattern detector with configurable length, overlap mode and saturating match counter
module pattern_seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [4:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cnt_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               cfg_err
);

  localparam logic [4:0]       LEN_MAX = 5'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [4:0]         len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [4:0]         fill_q, fill_d;
  logic               detected_q, detected_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic               err_q, err_d;

  logic               cfg_ok;
  logic               match;
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [4:0]         fill_inc;
  logic [CNT_W-1:0]   count_inc;

  always_comb begin
    cfg_ok = (cfg_len >= 5'd2) && (cfg_len <= LEN_MAX);
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (5'(i) < len_q);
    end
    hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + 5'd1;
    count_inc  = count_q + CNT_W'(1);
    // A load in the same cycle wins, so the incoming bit can never match.
    match = in_valid && !cfg_load && (fill_inc >= len_q) &&
            ((hist_shift & len_mask) == (pattern_q & len_mask));

    pattern_d  = pattern_q;
    len_d      = len_q;
    overlap_d  = overlap_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    count_d    = count_q;
    sat_d      = sat_q;
    detected_d = match;
    err_d      = cfg_load && !cfg_ok;

    if (cfg_load) begin
      if (cfg_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        hist_d    = '0;
        fill_d    = '0;
      end
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = (match && !overlap_q) ? 5'd0 : fill_inc;
    end

    if (cnt_clr) begin
      count_d = match ? CNT_W'(1) : '0;
      sat_d   = 1'b0;
    end else if (match) begin
      if (count_q != CNT_MAX) count_d = count_inc;
      if (count_q == CNT_MAX || count_inc == CNT_MAX) sat_d = 1'b1;
    end

    if (cfg_load && cfg_ok) begin
      count_d = '0;
      sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q  <= '0;
      len_q      <= 5'd2;
      overlap_q  <= 1'b1;
      hist_q     <= '0;
      fill_q     <= '0;
      detected_q <= 1'b0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pattern_q  <= pattern_d;
      len_q      <= len_d;
      overlap_q  <= overlap_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      detected_q <= detected_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
    end
  end

  assign detected    = detected_q;
  assign match_count = count_q;
  assign count_sat   = sat_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// tb/tb_pattern_seq_detector.sv - scoreboard bench for pattern_seq_detector (MAX_LEN=8, CNT_W=3)
module tb_pattern_seq_detector;

  logic       clk = 1'b0;
  logic       reset, cfg_load, cfg_overlap, in_valid, in_bit, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [4:0] cfg_len;
  logic       detected, count_sat, cfg_err;
  logic [2:0] match_count;

  always #5 clk = ~clk;

  pattern_seq_detector #(.MAX_LEN(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
    .cnt_clr(cnt_clr), .detected(detected), .match_count(match_count),
    .count_sat(count_sat), .cfg_err(cfg_err)
  );

  typedef struct {
    int det;
    int cnt;
    int sat;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_pat, m_len, m_ovl, m_cnt, m_sat;
  int m_bits[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model(input logic ld, input int pat, input int len, input logic ovl,
                       input logic v, input logic b, input logic clr, input logic rst,
                       output exp_t e);
    int det;
    det   = 0;
    e.err = 0;
    if (rst) begin
      m_pat = 0; m_len = 2; m_ovl = 1; m_cnt = 0; m_sat = 0;
      m_bits.delete();
    end else begin
      if (ld) begin
        if (len >= 2 && len <= 8) begin
          m_pat = pat; m_len = len; m_ovl = int'(ovl);
          m_bits.delete();
          m_cnt = 0; m_sat = 0;
        end else begin
          e.err = 1;
        end
      end else if (v) begin
        m_bits.push_back(int'(b));
        if (m_bits.size() > 16) void'(m_bits.pop_front());
        if (m_bits.size() >= m_len) begin
          det = 1;
          for (int k = 0; k < m_len; k++)
            if (m_bits[m_bits.size() - 1 - k] != ((m_pat >> k) & 1)) det = 0;
        end
        if (det == 1 && m_ovl == 0) m_bits.delete();
      end
      if (clr) begin
        m_cnt = det;
        m_sat = 0;
      end else if (det == 1) begin
        if (m_cnt < 7) m_cnt++;
        if (m_cnt == 7) m_sat = 1;
      end
    end
    e.det = det;
    e.cnt = m_cnt;
    e.sat = m_sat;
  endtask

  task automatic step(input logic ld, input int pat, input int len, input logic ovl,
                      input logic v, input logic b, input logic clr, input logic rst,
                      input string tag);
    exp_t e;
    reset       = rst;
    cfg_load    = ld;
    cfg_pattern = pat[7:0];
    cfg_len     = len[4:0];
    cfg_overlap = ovl;
    in_valid    = v;
    in_bit      = b;
    cnt_clr     = clr;
    model(ld, pat, len, ovl, v, b, clr, rst, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_det"}, int'(detected), e.det);
    check({tag, "_cnt"}, int'(match_count), e.cnt);
    check({tag, "_sat"}, int'(count_sat), e.sat);
    check({tag, "_err"}, int'(cfg_err), e.err);
    reset = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic bitv(input logic v, input logic b, input string tag);
    step(1'b0, 0, 0, 1'b0, v, b, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input int pat, input int len, input logic ovl, input string tag);
    step(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic stream(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) bitv(1'b1, bits[i], tag);
  endtask

  initial begin
    logic [31:0] s;
    int          pat, len;
    logic        ovl;
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; cnt_clr = 1'b0;

    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst");
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst");
    check("rst_det_const", int'(detected), 0);
    check("rst_cnt_const", int'(match_count), 0);

    load(32'b1011, 4, 1'b1, "ld_ovl");
    s = 32'b1011011;
    stream(s, 7, "ovl");
    check("ovl_total", int'(match_count), 2);

    load(32'b1011, 4, 1'b0, "ld_novl");
    stream(s, 7, "novl");
    check("novl_total", int'(match_count), 1);

    load(32'b1011, 4, 1'b1, "ld_gap");
    for (int i = 6; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) bitv(1'b0, 1'($urandom), "gap_idle");
      bitv(1'b1, s[i], "gap");
    end
    check("gap_total", int'(match_count), 2);

    load(32'b0110, 4, 1'b1, "ld_good");
    load(32'b1111, 1, 1'b0, "ld_len1");
    load(32'b1111, 9, 1'b0, "ld_len9");
    stream(32'b0110, 4, "keep");
    check("keep_total", int'(match_count), 1);

    load(32'b11, 2, 1'b1, "ld_sat");
    stream(32'h3ff, 10, "sat");
    check("sat_cnt_const", int'(match_count), 7);
    check("sat_flag_const", int'(count_sat), 1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");
    check("clr_cnt_const", int'(match_count), 0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "clr_match");
    check("clr_match_const", int'(match_count), 1);

    load(32'hf5, 3, 1'b1, "ld_hi");
    step(1'b1, 32'hf5, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "ld_with_bit");
    stream(32'b101, 3, "hi_bits");
    check("hi_total", int'(match_count), 1);

    load(32'b1011, 4, 1'b1, "ld_mid");
    stream(32'b101, 3, "mid");
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid_rst");
    bitv(1'b1, 1'b1, "mid_last");
    check("mid_nodet", int'(detected), 0);
    load(32'b1011, 4, 1'b1, "ld_post");
    stream(32'b1011, 4, "post");
    check("post_det", int'(detected), 1);

    for (int t = 0; t < 4; t++) begin
      pat = int'($urandom_range(0, 255));
      len = int'($urandom_range(2, 4));
      ovl = 1'($urandom);
      load(pat, len, ovl, "ld_rnd");
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 19) == 0)
          step(1'b0, 0, 0, 1'b0, 1'b1, 1'($urandom), 1'b1, 1'b0, "rnd_clr");
        else
          bitv(1'($urandom_range(0, 3) != 0), 1'($urandom), "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_seq_detector.md
PATTERN_SEQ_DETECTOR -- requirements
Module: pattern_seq_detector

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning the longest detectable pattern in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the match-counter width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_load  input  1  one-cycle strobe that latches a new configuration.
REQ-006 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first-received bit and bit [0] the last-received bit.
REQ-007 SHALL have port cfg_len  input  5  pattern length in bits.
REQ-008 SHALL have port cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-009 SHALL have port in_valid  input  1  qualifies in_bit.
REQ-010 SHALL have port in_bit  input  1  serial data bit.
REQ-011 SHALL have port cnt_clr  input  1  clears the match counter.
REQ-012 SHALL have port detected  output  1  one-cycle match pulse.
REQ-013 SHALL have port match_count  output  CNT_W  number of matches.
REQ-014 SHALL have port count_sat  output  1  sticky flag; counter has saturated.
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse; a cfg_load was rejected.

Function
REQ-016 SHALL keep a history shift register of MAX_LEN bits plus a fill counter (0..MAX_LEN); on each in_valid cycle, shift in_bit in at bit 0 and increment the fill counter, saturating at MAX_LEN.
REQ-017 SHALL ignore in_bit and hold all state when in_valid=0, except for the cfg_load, cnt_clr and reset actions.
REQ-018 SHALL declare a match on an accepting edge when both conditions hold after the shift:
  - the fill counter is >= len;
  - history[len-1:0] == pattern[len-1:0].
REQ-019 SHALL register detected high for exactly the one cycle following a matching edge; latency from the final pattern bit sampled to detected is 1 cycle.
REQ-020 SHALL drive detected low in all other cycles; back-to-back matches produce consecutive high cycles.
REQ-021 SHALL, in overlap mode, leave the history intact after a match (e.g. pattern 11, len 2, input 111 gives 2 matches).
REQ-022 SHALL, in non-overlap mode, reset the fill counter to 0 on a match (pattern 11, input 1111 gives 2 matches, input 111 gives 1).
REQ-023 SHALL increment match_count by 1 per match.
REQ-024 SHALL, at all-ones, hold match_count there and set count_sat; count_sat clears only on cnt_clr, cfg_load or reset.
REQ-025 SHALL on cnt_clr zero match_count and count_sat; a match in the same cycle yields match_count=1.
REQ-026 SHALL accept cfg_load only when 2 <= cfg_len <= MAX_LEN.
REQ-027 SHALL on an accepted cfg_load:
  - latch cfg_pattern, cfg_len and cfg_overlap;
  - clear the history, fill counter, match_count and count_sat;
  - suppress detected next cycle.
REQ-028 SHALL on a rejected cfg_load keep the prior configuration and all state, and pulse cfg_err next cycle.
REQ-029 SHALL give cfg_load priority over in_valid in the same cycle; the bit is discarded.
REQ-030 SHALL ignore pattern bits at position len and above in the comparison.

Reset
REQ-031 SHALL on reset set the following, overriding all other inputs:
  - history=0, fill=0, detected=0, match_count=0, count_sat=0, cfg_err=0;
  - pattern=0, len=2, overlap=1.
REQ-032 SHALL, on reset asserted mid-pattern, discard the partial history; no match completes using bits received before reset.

Verification
REQ-033 SHALL cover: load pattern 0b1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 -> detected high after bits 4 and 7, match_count=2.
REQ-034 SHALL cover: same pattern with overlap=0, same stream -> detected after bit 4 only, match_count=1.
REQ-035 SHALL cover: in_valid toggling 0/1 while streaming pattern bits -> match timing depends only on valid bits, and detected never asserts on an invalid cycle's edge.
REQ-036 SHALL cover: cfg_len=1 and cfg_len=MAX_LEN+1 loads -> cfg_err pulses, configuration unchanged, prior pattern still detected.
REQ-037 SHALL cover: CNT_W=3 with 9 matches -> match_count holds 7 and count_sat=1; then cnt_clr -> 0/0.
REQ-038 SHALL cover: reset asserted after 3 of 4 pattern bits, then the last bit -> no detection; a full pattern afterwards -> detection.
